// File: rtl/riscv_mem_sys.sv
// riscv_mem_sys: unified instruction/data RAM, a small MMIO block and a
// FIFO-fed UART transmitter for a single-cycle RISC-V core.
//
// Ports
//   clk, rst            single clock, synchronous active-high reset
//   PC, Instruction     combinational instruction fetch (word-aligned)
//   Address, MemWrite,  data port; ReadData is combinational from Address
//   WriteData, MemRead,
//   ReadData
//   cycle_cnt, inst_cnt core counters captured by a snapshot write
//   uart_tx             serial line, idle high, 8N1, TX_DIV clocks per bit
//   halt                sticky program-finished flag
//
// Handshake: the data port has no valid/ready pair. MemWrite is a per-cycle
// write strobe committed at the rising edge; reads are combinational and
// always accepted. MemRead does not gate anything.
//
// Memory map
//   0x0xxx_xxxx  RAM (word index Address[AW+1:2], higher bits alias)
//   0xCxxx_xxxx  MMIO decoded on Address[4:2]
//     +0x00 TXDATA (W)  +0x04 STATUS (R)  +0x08 HALT (RW)
//     +0x10 SNAP_CYC    +0x14 SNAP_INST
//   anything else reads 0, writes ignored
module riscv_mem_sys #(
  parameter int MEM_WORDS = 1024,
  parameter int TX_DIV    = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] PC,
  output logic [31:0] Instruction,
  input  logic [31:0] Address,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  input  logic        MemRead,
  output logic [31:0] ReadData,
  input  logic [31:0] cycle_cnt,
  input  logic [31:0] inst_cnt,
  output logic        uart_tx,
  output logic        halt
);

  localparam int AW = $clog2(MEM_WORDS);
  localparam int DW = (TX_DIV > 1) ? $clog2(TX_DIV) : 1;
  localparam logic [DW-1:0] DIV_LAST = DW'(TX_DIV - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_START = 2'd1;
  localparam logic [1:0] S_DATA  = 2'd2;
  localparam logic [1:0] S_STOP  = 2'd3;

  // ---------------------------------------------------------------- decode
  logic       ram_sel;
  logic       mmio_sel;
  logic [2:0] mmio_off;
  logic       unused_bits;

  assign ram_sel  = (Address[31:28] == 4'h0);
  assign mmio_sel = (Address[31:28] == 4'hC);
  assign mmio_off = Address[4:2];
  assign unused_bits = ^{MemRead, Address[27:AW+2], Address[1:0],
                         PC[31:AW+2], PC[1:0]};

  // ------------------------------------------------------------------- RAM
  // No reset on the array: program contents survive rst. A write in the
  // reset cycle is suppressed so rst wins over MemWrite.
  logic [31:0] mem_q [MEM_WORDS];

  always_ff @(posedge clk) begin
    if (!rst && MemWrite && ram_sel) mem_q[Address[AW+1:2]] <= WriteData;
  end

  assign Instruction = mem_q[PC[AW+1:2]];

  // ------------------------------------------------------------- TX FIFO
  logic [7:0] fifo_q [8];
  logic [2:0] wr_ptr_q, rd_ptr_q;
  logic [3:0] count_q;
  logic       ovf_q;
  logic       fifo_full, fifo_empty;
  logic       push_req, push_ok, pop;

  assign fifo_full  = (count_q == 4'd8);
  assign fifo_empty = (count_q == 4'd0);
  assign push_req   = MemWrite && mmio_sel && (mmio_off == 3'd0);
  // A pop in the same edge frees the slot, so a full FIFO still accepts.
  assign push_ok    = push_req && (!fifo_full || pop);

  always_ff @(posedge clk) begin
    if (push_ok) fifo_q[wr_ptr_q] <= WriteData[7:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= 3'd0;
      rd_ptr_q <= 3'd0;
      count_q  <= 4'd0;
      ovf_q    <= 1'b0;
    end else begin
      if (push_ok) wr_ptr_q <= wr_ptr_q + 3'd1;
      if (pop)     rd_ptr_q <= rd_ptr_q + 3'd1;
      case ({push_ok, pop})
        2'b10:   count_q <= count_q + 4'd1;
        2'b01:   count_q <= count_q - 4'd1;
        default: count_q <= count_q;
      endcase
      if (push_req && !push_ok) ovf_q <= 1'b1;
    end
  end

  // ---------------------------------------------------------------- TX FSM
  logic [1:0]    state_q, state_d;
  logic [DW-1:0] div_q, div_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          div_last;

  assign div_last = (div_q == DIV_LAST);

  always_comb begin
    state_d = state_q;
    div_d   = div_q;
    bit_d   = bit_q;
    shift_d = shift_q;
    pop     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (!fifo_empty) begin
          pop     = 1'b1;
          shift_d = fifo_q[rd_ptr_q];
          div_d   = '0;
          state_d = S_START;
        end
      end
      S_START: begin
        if (div_last) begin
          div_d   = '0;
          bit_d   = 3'd0;
          state_d = S_DATA;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      S_DATA: begin
        if (div_last) begin
          div_d = '0;
          if (bit_q == 3'd7) state_d = S_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: begin // S_STOP
        if (div_last) begin
          div_d = '0;
          // Chain straight into the next start bit: no idle gap.
          if (!fifo_empty) begin
            pop     = 1'b1;
            shift_d = fifo_q[rd_ptr_q];
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      div_q   <= '0;
      bit_q   <= 3'd0;
      shift_q <= 8'd0;
    end else begin
      state_q <= state_d;
      div_q   <= div_d;
      bit_q   <= bit_d;
      shift_q <= shift_d;
    end
  end

  always_comb begin
    case (state_q)
      S_START: uart_tx = 1'b0;
      S_DATA:  uart_tx = shift_q[bit_q];
      default: uart_tx = 1'b1;
    endcase
  end

  // ------------------------------------------------------ halt / snapshots
  logic        halt_q;
  logic [31:0] snap_cyc_q, snap_inst_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      halt_q      <= 1'b0;
      snap_cyc_q  <= 32'd0;
      snap_inst_q <= 32'd0;
    end else if (MemWrite && mmio_sel) begin
      if (mmio_off == 3'd2) halt_q <= 1'b1;
      // Either snapshot address captures both counters together.
      if (mmio_off == 3'd4 || mmio_off == 3'd5) begin
        snap_cyc_q  <= cycle_cnt;
        snap_inst_q <= inst_cnt;
      end
    end
  end

  assign halt = halt_q;

  // -------------------------------------------------------------- read mux
  always_comb begin
    ReadData = 32'd0;
    if (ram_sel) begin
      ReadData = mem_q[Address[AW+1:2]];
    end else if (mmio_sel) begin
      case (mmio_off)
        3'd1:    ReadData = {28'd0, ovf_q, fifo_full, fifo_empty, state_q != S_IDLE};
        3'd2:    ReadData = {31'd0, halt_q};
        3'd4:    ReadData = snap_cyc_q;
        3'd5:    ReadData = snap_inst_q;
        default: ReadData = 32'd0;
      endcase
    end
  end

endmodule
